// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the memory-map slave.
// Registered grant, round-robin or fixed priority, bus watchdog returning err on a hung slave.
module wb_mem_arbiter #(
  parameter int AW      = 20,
  parameter int DW      = 16,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m0_we_i,
  input  logic          m0_byte_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic          m1_we_i,
  input  logic          m1_byte_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_we_o,
  output logic          s_byte_o,
  output logic          s_stb_o,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o,
  output logic          busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // A zero-width timer is illegal, so a disabled watchdog still keeps one (constant) bit.
  localparam int             TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;

  logic in_gnt;
  logic sel_m1;
  logic stb_sel;
  logic tmo;

  always_comb begin
    in_gnt  = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    sel_m1  = (state_q == ST_GNT1);
    stb_sel = sel_m1 ? m1_stb_i : m0_stb_i;
    // An ack in the final watchdog cycle still completes the transfer normally.
    tmo     = (TIMEOUT != 0) && in_gnt && (timer_q == TMO_LAST) && !s_ack_i;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (m0_stb_i && m1_stb_i) begin
          state_d = ((RR != 0) && !last_q) ? ST_GNT1 : ST_GNT0;
        end else if (m0_stb_i) begin
          state_d = ST_GNT0;
        end else if (m1_stb_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (s_ack_i || !stb_sel || tmo) begin
          state_d = ST_IDLE;
          last_d  = sel_m1;
          timer_d = '0;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Outputs decode straight from the registered state so reset clears them asynchronously.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_byte_o = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    if (in_gnt) begin
      s_stb_o = stb_sel && !tmo;
      if (sel_m1) begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_byte_o = m1_byte_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        m1_err_o = tmo && m1_stb_i;
      end else begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_byte_o = m0_byte_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        m0_err_o = tmo && m0_stb_i;
      end
    end
  end

  assign gnt_o  = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a round-robin instance with an 8-cycle watchdog checked through a
// response scoreboard, plus a fixed-priority instance with the watchdog disabled.
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] slave_data(input logic [19:0] adr);
    return (adr == 20'h00100) ? 16'hBEEF : (adr[15:0] ^ 16'h5A5A);
  endfunction

  // ---------------- instance A: RR=1, TIMEOUT=8 ----------------
  logic [19:0] m0_adr = '0, m1_adr = '0, s_adr;
  logic [15:0] m0_wdat = '0, m1_wdat = '0, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic        m0_we = 0, m1_we = 0, m0_byte = 0, m1_byte = 0, m0_stb = 0, m1_stb = 0;
  logic        m0_ack, m1_ack, m0_err, m1_err, s_we, s_byte, s_stb, busy;
  logic        s_ack = 1'b0;
  logic [1:0]  gnt;

  assign s_rdat = slave_data(s_adr);

  wb_mem_arbiter #(.AW(20), .DW(16), .RR(1), .TIMEOUT(8)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_byte_i(m0_byte), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_byte_i(m1_byte), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_we_o(s_we),
    .s_byte_o(s_byte), .s_stb_o(s_stb), .s_ack_i(s_ack), .gnt_o(gnt), .busy_o(busy)
  );

  // Slave A acks once s_stb_o has been high for a_delay full cycles.
  int a_delay = 1000;
  int a_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (s_stb) begin
      s_ack <= (a_cnt == a_delay);
      a_cnt <= a_cnt + 1;
    end else begin
      s_ack <= 1'b0;
      a_cnt <= 0;
    end
  end

  // Scoreboard: kind[0] = master 1, kind[1] = error response.
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] dat;
  } exp_t;
  exp_t sb_q[$];

  function automatic exp_t mk(input logic [1:0] kind, input logic [15:0] dat);
    exp_t e;
    e.kind = kind;
    e.dat  = dat;
    return e;
  endfunction

  exp_t       mon_e;
  logic [1:0] mon_kind;
  logic       exp_idle = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_not_both", {31'd0, gnt == 2'b11}, 32'd0);
      if (exp_idle) check("idle_after_resp", {30'd0, gnt}, 32'd0);
      exp_idle = 1'b0;
      if (m0_ack || m0_err || m1_ack || m1_err) begin
        exp_idle = 1'b1;
        mon_kind = {m0_err || m1_err, m1_ack || m1_err};
        check("single_master_resp", {31'd0, (m0_ack || m0_err) && (m1_ack || m1_err)}, 32'd0);
        $display("[TB] txn m%0d %s dat=%h", mon_kind[0], mon_kind[1] ? "err" : "ack",
                 mon_kind[0] ? m1_rdat : m0_rdat);
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_kind", {30'd0, mon_kind}, {30'd0, mon_e.kind});
          if (!mon_e.kind[1]) check("resp_data", {16'd0, mon_kind[0] ? m1_rdat : m0_rdat}, {16'd0, mon_e.dat});
          check("other_dat_zero", {16'd0, mon_kind[0] ? m0_rdat : m1_rdat}, 32'd0);
        end
      end
    end
  end

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, sb_q.size(), 32'd0);
  endtask

  // ---------------- instance B: RR=0, TIMEOUT=0 ----------------
  logic [19:0] fp_m0_adr = 20'h00010, fp_m1_adr = 20'h00020, fp_s_adr;
  logic [15:0] fp_m0_rdat, fp_m1_rdat, fp_s_wdat;
  logic [15:0] fp_s_rdat = 16'h1234;
  logic        fp_m0_stb = 0, fp_m1_stb = 0, fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err;
  logic        fp_s_we, fp_s_byte, fp_s_stb, fp_busy;
  logic        fp_s_ack = 1'b0, fp_ack_en = 1'b0;
  logic [1:0]  fp_gnt;

  wb_mem_arbiter #(.AW(20), .DW(16), .RR(0), .TIMEOUT(0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_adr_i(fp_m0_adr), .m0_dat_i(16'h0000), .m0_dat_o(fp_m0_rdat), .m0_we_i(1'b0),
    .m0_byte_i(1'b0), .m0_stb_i(fp_m0_stb), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
    .m1_adr_i(fp_m1_adr), .m1_dat_i(16'h0000), .m1_dat_o(fp_m1_rdat), .m1_we_i(1'b0),
    .m1_byte_i(1'b0), .m1_stb_i(fp_m1_stb), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
    .s_adr_o(fp_s_adr), .s_dat_o(fp_s_wdat), .s_dat_i(fp_s_rdat), .s_we_o(fp_s_we),
    .s_byte_o(fp_s_byte), .s_stb_o(fp_s_stb), .s_ack_i(fp_s_ack), .gnt_o(fp_gnt), .busy_o(fp_busy)
  );

  always @(posedge clk) begin
    #2;
    fp_s_ack <= fp_ack_en && fp_s_stb;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int hi;
    int acks;
    int errs;
    logic seen;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb", {31'd0, s_stb}, 32'd0);
    check("rst_adr", {12'd0, s_adr}, 32'd0);
    check("rst_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check("rst_fp_gnt", {30'd0, fp_gnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin with both requests held: m0 first after reset, then alternate
    m0_adr = 20'h00200;
    m1_adr = 20'h12345;
    a_delay = 1;
    m0_stb = 1'b1;
    m1_stb = 1'b1;
    sb_q.push_back(mk(2'b00, slave_data(20'h00200)));
    sb_q.push_back(mk(2'b01, slave_data(20'h12345)));
    sb_q.push_back(mk(2'b00, slave_data(20'h00200)));
    sb_q.push_back(mk(2'b01, slave_data(20'h12345)));
    tick();
    check("rr_first_gnt", {30'd0, gnt}, 32'd1);
    wait_sb("rr_alternate_done", 40);
    m0_stb = 1'b0;
    m1_stb = 1'b0;

    // m0 read of 0x00100, slave acks two cycles after strobe
    tick();
    m0_adr = 20'h00100;
    m0_we = 1'b0;
    a_delay = 2;
    m0_stb = 1'b1;
    sb_q.push_back(mk(2'b00, 16'hBEEF));
    tick();
    check("rd_gnt", {30'd0, gnt}, 32'd1);
    check("rd_stb", {31'd0, s_stb}, 32'd1);
    check("rd_adr", {12'd0, s_adr}, 32'h00100);
    check("rd_busy", {31'd0, busy}, 32'd1);
    wait_sb("rd_done", 20);
    m0_stb = 1'b0;
    check("rd_gnt_after", {30'd0, gnt}, 32'd0);

    // Watchdog: slave never acks
    tick();
    a_delay = 1000;
    m0_stb = 1'b1;
    sb_q.push_back(mk(2'b10, 16'h0000));
    hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_stb) hi++;
      if (m0_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("tmo_err_seen", {31'd0, seen}, 32'd1);
    check("tmo_stb_cycles", hi, 32'd7);
    @(negedge clk);
    check("tmo_busy_after", {31'd0, busy}, 32'd0);
    m0_stb = 1'b0;
    check("tmo_sb_empty", sb_q.size(), 32'd0);

    // m1 aborts in its 2nd grant cycle; pending m0 then granted
    tick();
    m0_adr = 20'h00040;
    m1_adr = 20'h00080;
    m0_stb = 1'b1;
    m1_stb = 1'b1;
    tick();
    check("ab_gnt_m1", {30'd0, gnt}, 32'd2);
    tick();
    m1_stb = 1'b0;
    a_delay = 0;
    sb_q.push_back(mk(2'b00, slave_data(20'h00040)));
    tick();
    check("ab_idle_gnt", {30'd0, gnt}, 32'd0);
    check("ab_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("ab_then_m0", {30'd0, gnt}, 32'd1);
    wait_sb("ab_m0_done", 10);
    m0_stb = 1'b0;

    // Reset in the middle of an m1 write
    tick();
    a_delay = 1000;
    m1_adr = 20'h0ABCD;
    m1_wdat = 16'hC0DE;
    m1_we = 1'b1;
    m1_stb = 1'b1;
    tick();
    check("wr_gnt", {30'd0, gnt}, 32'd2);
    check("wr_we", {31'd0, s_we}, 32'd1);
    check("wr_dat", {16'd0, s_wdat}, 32'h0000C0DE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stb", {31'd0, s_stb}, 32'd0);
    check("arst_we", {31'd0, s_we}, 32'd0);
    check("arst_gnt", {30'd0, gnt}, 32'd0);
    check("arst_dat", {16'd0, s_wdat}, 32'd0);
    m1_stb = 1'b0;
    m1_we = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_adr = 20'h00300;
    m1_adr = 20'h00400;
    a_delay = 0;
    m0_stb = 1'b1;
    m1_stb = 1'b1;
    sb_q.push_back(mk(2'b00, slave_data(20'h00300)));
    tick();
    check("arst_tie_m0", {30'd0, gnt}, 32'd1);
    wait_sb("arst_m0_done", 10);
    m0_stb = 1'b0;
    m1_stb = 1'b0;

    // Fixed priority: m1 starves while m0 keeps requesting
    tick();
    fp_ack_en = 1'b1;
    fp_m0_stb = 1'b1;
    fp_m1_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("fp_m1_blocked", {31'd0, fp_gnt == 2'b10}, 32'd0);
      if (fp_m0_ack) acks++;
    end
    check("fp_m0_acks", {31'd0, acks >= 8}, 32'd1);
    tick();
    fp_ack_en = 1'b0;
    fp_m0_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fp_gnt == 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    check("fp_m1_granted", {31'd0, seen}, 32'd1);

    // Watchdog disabled: a hung slave holds the grant with no error
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fp_m1_err || fp_m0_err) errs++;
    end
    check("fp_no_err", errs, 32'd0);
    check("fp_hold_gnt", {30'd0, fp_gnt}, 32'd2);
    check("fp_hold_stb", {31'd0, fp_s_stb}, 32'd1);
    fp_ack_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fp_m1_ack) begin
        seen = 1'b1;
        check("fp_m1_dat", {16'd0, fp_m1_rdat}, 32'h00001234);
        break;
      end
    end
    check("fp_m1_ack", {31'd0, seen}, 32'd1);
    tick();
    fp_m1_stb = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
